// File: rtl/regbank_pkg.sv
// Shared defaults and clear-sequencer state encoding for the MIPS register bank.
package regbank_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } regbank_state_t;

endpackage

// File: rtl/regbank_clear_fsm.sv
// Post-reset clear sequencer: walks idx across every entry, one per cycle, with busy held high.
module regbank_clear_fsm
  import regbank_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  output regbank_state_t    state,
  output logic [ADDR_W-1:0] idx,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'((1 << ADDR_W) - 1);

  // Leaving CLEAR is keyed on the last index, not on idx wrapping to zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_CLEAR;
      idx   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        ST_CLEAR: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= ST_RUN;
            busy  <= 1'b0;
          end
        end
        ST_RUN: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/banco_registradores.sv
// 32-entry MIPS register bank: two combinational read ports, one synchronous write port.
// Define REGBANK_WRITE_BYPASS_EN for write-first reads; otherwise reads are read-first.
module banco_registradores
  import regbank_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              busy
);

  localparam int NUM_REGS = 1 << ADDR_W;

`ifdef REGBANK_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic [DATA_W-1:0] mem [NUM_REGS];
  regbank_state_t    state;
  logic [ADDR_W-1:0] idx;
  logic              do_write;

  regbank_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk   (clk),
    .reset (reset),
    .state (state),
    .idx   (idx),
    .busy  (busy)
  );

  assign do_write = (state == ST_RUN) && reg_write && (write_reg != '0);

  // The reset edge itself writes nothing; CLEAR owns the array until it finishes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == ST_CLEAR) begin
        mem[idx] <= '0;
      end else if (do_write) begin
        mem[write_reg] <= write_data;
      end
    end
  end

  always_comb begin
    read_data1 = '0;
    if (state == ST_RUN && read_reg1 != '0) begin
      if (BYPASS && do_write && write_reg == read_reg1) begin
        read_data1 = write_data;
      end else begin
        read_data1 = mem[read_reg1];
      end
    end
  end

  always_comb begin
    read_data2 = '0;
    if (state == ST_RUN && read_reg2 != '0) begin
      if (BYPASS && do_write && write_reg == read_reg2) begin
        read_data2 = write_data;
      end else begin
        read_data2 = mem[read_reg2];
      end
    end
  end

endmodule

// File: tb/tb_banco_registradores.sv
// Directed and randomized checks for banco_registradores; honours REGBANK_WRITE_BYPASS_EN.
module tb_banco_registradores;

`ifdef REGBANK_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        reg_write;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        busy;

  int checkCount = 0;
  int passCount  = 0;
  logic [31:0] refm [32];

  banco_registradores dut (
    .clk        (clk),
    .reset      (reset),
    .reg_write  (reg_write),
    .read_reg1  (read_reg1),
    .read_reg2  (read_reg2),
    .write_reg  (write_reg),
    .write_data (write_data),
    .read_data1 (read_data1),
    .read_data2 (read_data2),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic applyStimulus(input logic rst, input logic rw, input logic [4:0] r1,
                               input logic [4:0] r2, input logic [4:0] wr, input logic [31:0] wd);
    reset      = rst;
    reg_write  = rw;
    read_reg1  = r1;
    read_reg2  = r2;
    write_reg  = wr;
    write_data = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts consecutive busy-high samples, one per cycle, bounded so a stuck busy still ends.
  task automatic countBusy(output int n);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy !== 1'b1) break;
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    int m;
    logic [31:0] exp1;
    logic [31:0] exp2;

    // Test 1: single-cycle reset, busy for 32 cycles, all registers zero.
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    countBusy(n);
    checkOutput("busy_len_after_reset", 32'(n), 32'd32);
    checkOutput("busy_low_after_clear", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1'b0, 1'b0, 5'(i), 5'(31 - i), 5'd0, 32'h0);
      checkOutput($sformatf("zero_rd1_r%0d", i), read_data1, 32'h0);
      checkOutput($sformatf("zero_rd2_r%0d", 31 - i), read_data2, 32'h0);
    end

    // Test 2: writes to r0 are discarded, also in the write cycle itself.
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF);
    checkOutput("r0_during_write", read_data1, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    checkOutput("r0_after_write", read_data1, 32'h0);

    // Test 3: independent read ports.
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'h0000_1234);
    tick();
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd31, 32'hFFFF_FFFF);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd5, 5'd31, 5'd0, 32'h0);
    checkOutput("rd1_r5", read_data1, 32'h0000_1234);
    checkOutput("rd2_r31", read_data2, 32'hFFFF_FFFF);
    applyStimulus(1'b0, 1'b0, 5'd31, 5'd31, 5'd0, 32'h0);
    checkOutput("same_reg_rd1", read_data1, 32'hFFFF_FFFF);
    checkOutput("same_reg_rd2", read_data2, 32'hFFFF_FFFF);

    // Test 4: same-cycle write and read of r7.
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h0000_0001);
    tick();
    applyStimulus(1'b0, 1'b1, 5'd5, 5'd7, 5'd7, 32'hA5A5_A5A5);
    checkOutput("r7_same_cycle", read_data2, BYPASS ? 32'hA5A5_A5A5 : 32'h0000_0001);
    checkOutput("r5_unaffected", read_data1, 32'h0000_1234);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd7, 5'd0, 32'h0);
    checkOutput("r7_next_cycle", read_data2, 32'hA5A5_A5A5);

    // Test 5: reset again partway through CLEAR; writes during CLEAR are dropped.
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd9, 32'h0000_0055);
    tick();
    applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 5'd20, 32'h0000_0077);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd9, 5'd20, 5'd0, 32'h0);
    checkOutput("r9_loaded", read_data1, 32'h0000_0055);
    checkOutput("r20_loaded", read_data2, 32'h0000_0077);
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    for (int i = 0; i < 10; i++) tick();
    applyStimulus(1'b0, 1'b0, 5'd20, 5'd0, 5'd0, 32'h0);
    checkOutput("rd_forced_zero_in_clear", read_data1, 32'h0);
    checkOutput("busy_mid_clear", {31'd0, busy}, 32'd1);
    applyStimulus(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b1, 5'd20, 5'd12, 5'd20, 32'h0000_0BAD);
    checkOutput("no_bypass_in_clear", read_data1, 32'h0);
    n = (busy === 1'b1) ? 1 : 0;
    tick();
    applyStimulus(1'b0, 1'b1, 5'd12, 5'd12, 5'd12, 32'h0000_0BAD);
    n += (busy === 1'b1) ? 1 : 0;
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0);
    countBusy(m);
    checkOutput("busy_len_after_second_reset", 32'(n + m), 32'd32);
    applyStimulus(1'b0, 1'b0, 5'd9, 5'd20, 5'd0, 32'h0);
    checkOutput("r9_cleared", read_data1, 32'h0);
    checkOutput("r20_dropped_write", read_data2, 32'h0);
    applyStimulus(1'b0, 1'b0, 5'd12, 5'd7, 5'd0, 32'h0);
    checkOutput("r12_dropped_write", read_data1, 32'h0);
    checkOutput("r7_cleared", read_data2, 32'h0);

    // Test 6: random traffic against a reference array.
    for (int i = 0; i < 32; i++) refm[i] = 32'h0;
    for (int c = 0; c < 10000; c++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                    5'($urandom), $urandom);
      exp1 = refm[read_reg1];
      exp2 = refm[read_reg2];
      if (BYPASS && reg_write && write_reg != 5'd0) begin
        if (write_reg == read_reg1) exp1 = write_data;
        if (write_reg == read_reg2) exp2 = write_data;
      end
      checkOutput($sformatf("rand_rd1_c%0d", c), read_data1, exp1);
      checkOutput($sformatf("rand_rd2_c%0d", c), read_data2, exp2);
      if (reg_write && write_reg != 5'd0) refm[write_reg] = write_data;
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
